// File: rtl/elm_img_pkg.sv
// Shared types and default geometry for the ELM image front end.
// Consumers: image_stream_deserializer (optional feature macro ISD_IMG_COUNT_EN).
package elm_img_pkg;

  localparam int unsigned ISD_WORD_W_DEF        = 32;
  localparam int unsigned ISD_WORDS_PER_IMG_DEF = 8;
  localparam int unsigned ISD_CNT_W_DEF         = 16;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } isd_state_t;

endpackage : elm_img_pkg

// File: rtl/image_stream_deserializer.sv
// Packs WORDS_PER_IMG serial words into one image, double buffered, valid/ready on both sides.
// Define ISD_IMG_COUNT_EN to add the img_count port counting delivered images.
module image_stream_deserializer
  import elm_img_pkg::*;
#(
  parameter int unsigned WORD_W        = ISD_WORD_W_DEF,
  parameter int unsigned WORDS_PER_IMG = ISD_WORDS_PER_IMG_DEF,
  parameter int unsigned CNT_W         = ISD_CNT_W_DEF
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [WORD_W-1:0]               in_data,
  input  logic                            in_valid,
  input  logic                            in_last,
  output logic                            in_ready,
  output logic [WORD_W*WORDS_PER_IMG-1:0] out_image,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            frame_err
`ifdef ISD_IMG_COUNT_EN
  ,
  output logic [CNT_W-1:0]                img_count
`endif
);

  localparam int unsigned IMG_W = WORD_W * WORDS_PER_IMG;
  localparam int unsigned CW    = $clog2(WORDS_PER_IMG);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS_PER_IMG - 1);

  isd_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IMG_W-1:0] fill_q, fill_d;
  logic [IMG_W-1:0] out_image_q, out_image_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;

  logic [IMG_W-1:0] fill_shift;
  logic             out_free;

  // Earlier words migrate toward the MSBs, so word0 ends up in the top slice.
  assign fill_shift = {fill_q[IMG_W-WORD_W-1:0], in_data};
  assign out_free   = !out_valid_q || out_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    out_image_d = out_image_q;
    out_valid_d = out_valid_q && !out_ready;
    frame_err_d = 1'b0;

    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          fill_d = fill_shift;
          if (cnt_q == LAST_IDX) begin
            cnt_d = '0;
            if (!in_last) begin
              frame_err_d = 1'b1;
            end else if (out_free) begin
              out_image_d = fill_shift;
              out_valid_d = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end else if (in_last) begin
            frame_err_d = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      HOLD: begin
        if (out_free) begin
          out_image_d = fill_q;
          out_valid_d = 1'b1;
          state_d     = FILL;
        end
      end

      default: state_d = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset is synchronous
  // and clears the data registers too, so a partial or held image never survives it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      fill_q      <= '0;
      out_image_q <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      out_image_q <= out_image_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign out_image = out_image_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;

`ifdef ISD_IMG_COUNT_EN
  logic [CNT_W-1:0] img_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      img_count_q <= '0;
    end else if (out_valid_q && out_ready) begin
      img_count_q <= img_count_q + CNT_W'(1);
    end
  end

  assign img_count = img_count_q;
`else
  // CNT_W only sizes the optional counter; referenced here so the header stays uniform.
  if (CNT_W == 0) begin : g_no_counter
  end
`endif

endmodule : image_stream_deserializer

// File: tb/tb_image_stream_deserializer.sv
// Directed bench for image_stream_deserializer: default geometry plus an 8-bit x 4-word instance.
// img_count is checked only when ISD_IMG_COUNT_EN is defined.
module tb_image_stream_deserializer;

  logic clock = 1'b0;
  logic reset;

  logic [31:0]  a_in_data;
  logic         a_in_valid, a_in_last, a_in_ready;
  logic [255:0] a_out_image;
  logic         a_out_valid, a_out_ready, a_frame_err;
`ifdef ISD_IMG_COUNT_EN
  logic [15:0]  a_img_count;
`endif

  logic [7:0]   b_in_data;
  logic         b_in_valid, b_in_last, b_in_ready;
  logic [31:0]  b_out_image;
  logic         b_out_valid, b_out_ready, b_frame_err;
`ifdef ISD_IMG_COUNT_EN
  logic [1:0]   b_img_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  image_stream_deserializer u_dut_a (
    .clock     (clock),
    .reset     (reset),
    .in_data   (a_in_data),
    .in_valid  (a_in_valid),
    .in_last   (a_in_last),
    .in_ready  (a_in_ready),
    .out_image (a_out_image),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .frame_err (a_frame_err)
`ifdef ISD_IMG_COUNT_EN
    ,
    .img_count (a_img_count)
`endif
  );

  image_stream_deserializer #(
    .WORD_W        (8),
    .WORDS_PER_IMG (4),
    .CNT_W         (2)
  ) u_dut_b (
    .clock     (clock),
    .reset     (reset),
    .in_data   (b_in_data),
    .in_valid  (b_in_valid),
    .in_last   (b_in_last),
    .in_ready  (b_in_ready),
    .out_image (b_out_image),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .frame_err (b_frame_err)
`ifdef ISD_IMG_COUNT_EN
    ,
    .img_count (b_img_count)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one word for exactly one clock edge, then idles the input.
  task automatic send_a(input logic [31:0] d, input logic last);
    a_in_data  = d;
    a_in_last  = last;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
  endtask

  task automatic send_img_a(input logic [31:0] base);
    for (int j = 1; j <= 8; j++) send_a(base | 32'(j), j == 8);
  endtask

  task automatic send_b(input logic [7:0] d, input logic last);
    b_in_data  = d;
    b_in_last  = last;
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests_run++;
    if (a_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid: got %b want 0", a_out_valid);
    end
    tests_run++;
    if (a_out_image !== 256'h0) begin
      tests_failed++;
      $display("FAIL reset_out_image: got %h want 0", a_out_image);
    end
    tests_run++;
    if (a_in_ready !== 1'b1 || a_frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready_err: got ready=%b err=%b want 1/0", a_in_ready, a_frame_err);
    end
`ifdef ISD_IMG_COUNT_EN
    tests_run++;
    if (a_img_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_img_count: got %0d want 0", a_img_count);
    end
`endif
  endtask

  task automatic test_single_image();
    a_out_ready = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      send_a(32'(j), j == 8);
      if (j < 8) begin
        tests_run++;
        if (a_out_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL single_early_valid: word %0d got %b want 0", j, a_out_valid);
        end
      end
    end
    tests_run++;
    if (a_out_valid !== 1'b1 || a_frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_valid: got valid=%b err=%b want 1/0", a_out_valid, a_frame_err);
    end
    tests_run++;
    if (a_out_image !== 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008) begin
      tests_failed++;
      $display("FAIL single_image: got %h", a_out_image);
    end
    tick();
    tests_run++;
    if (a_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_drain: got %b want 0", a_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] exp_img [3];
    int n_out = 0;
    int last_cyc = 0;
    int cyc = 0;
    exp_img[0] = 256'hB0000001_B0000002_B0000003_B0000004_B0000005_B0000006_B0000007_B0000008;
    exp_img[1] = 256'hB1000001_B1000002_B1000003_B1000004_B1000005_B1000006_B1000007_B1000008;
    exp_img[2] = 256'hB2000001_B2000002_B2000003_B2000004_B2000005_B2000006_B2000007_B2000008;
    a_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int j = 1; j <= 8; j++) begin
        tests_run++;
        if (a_in_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_in_ready: img %0d word %0d got %b want 1", k, j, a_in_ready);
        end
        send_a(32'hB000_0000 | (32'(k) << 24) | 32'(j), j == 8);
        cyc++;
        if (a_out_valid === 1'b1) begin
          tests_run++;
          if (n_out > 2 || a_out_image !== exp_img[n_out % 3]) begin
            tests_failed++;
            $display("FAIL b2b_image: output %0d got %h", n_out, a_out_image);
          end
          if (n_out > 0) begin
            tests_run++;
            if (cyc - last_cyc != 8) begin
              tests_failed++;
              $display("FAIL b2b_spacing: got %0d cycles want 8", cyc - last_cyc);
            end
          end
          last_cyc = cyc;
          n_out++;
        end
      end
    end
    tests_run++;
    if (n_out != 3) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d outputs want 3", n_out);
    end
    tick();
  endtask

  task automatic test_hold();
    a_out_ready = 1'b0;
    send_img_a(32'hC000_0000);
    tests_run++;
    if (a_out_valid !== 1'b1 || a_out_image[255 -: 32] !== 32'hC0000001) begin
      tests_failed++;
      $display("FAIL hold_first: got valid=%b top=%h want 1/c0000001", a_out_valid, a_out_image[255 -: 32]);
    end
    for (int j = 1; j <= 8; j++) begin
      tests_run++;
      if (a_in_ready !== 1'b1 || a_out_image[31:0] !== 32'hC0000008) begin
        tests_failed++;
        $display("FAIL hold_fill: word %0d got ready=%b low=%h", j, a_in_ready, a_out_image[31:0]);
      end
      send_a(32'hC100_0000 | 32'(j), j == 8);
    end
    tests_run++;
    if (a_in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_in_ready: got %b want 0", a_in_ready);
    end
    tick();
    tick();
    tests_run++;
    if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 ||
        a_out_image !== 256'hC0000001_C0000002_C0000003_C0000004_C0000005_C0000006_C0000007_C0000008) begin
      tests_failed++;
      $display("FAIL hold_stable: got valid=%b ready=%b img=%h", a_out_valid, a_in_ready, a_out_image);
    end
    a_out_ready = 1'b1;
    tick();
    tests_run++;
    if (a_out_valid !== 1'b1 || a_in_ready !== 1'b1 ||
        a_out_image !== 256'hC1000001_C1000002_C1000003_C1000004_C1000005_C1000006_C1000007_C1000008) begin
      tests_failed++;
      $display("FAIL hold_release: got valid=%b ready=%b img=%h", a_out_valid, a_in_ready, a_out_image);
    end
    tick();
    tests_run++;
    if (a_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_drain: got %b want 0", a_out_valid);
    end
  endtask

  task automatic test_early_last();
    a_out_ready = 1'b1;
    for (int j = 1; j <= 5; j++) send_a(32'hD000_0000 | 32'(j), j == 5);
    tests_run++;
    if (a_frame_err !== 1'b1 || a_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_last_err: got err=%b valid=%b want 1/0", a_frame_err, a_out_valid);
    end
    tick();
    tests_run++;
    if (a_frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_last_pulse: got %b want 0", a_frame_err);
    end
    send_img_a(32'hE000_0000);
    tests_run++;
    if (a_out_valid !== 1'b1 || a_frame_err !== 1'b0 ||
        a_out_image !== 256'hE0000001_E0000002_E0000003_E0000004_E0000005_E0000006_E0000007_E0000008) begin
      tests_failed++;
      $display("FAIL early_last_recover: got valid=%b err=%b img=%h", a_out_valid, a_frame_err, a_out_image);
    end
    tick();
  endtask

  task automatic test_missing_last_and_reset();
    a_out_ready = 1'b1;
    for (int j = 1; j <= 8; j++) send_a(32'hF000_0000 | 32'(j), 1'b0);
    tests_run++;
    if (a_frame_err !== 1'b1 || a_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL missing_last_err: got err=%b valid=%b want 1/0", a_frame_err, a_out_valid);
    end
    tick();
    a_out_ready = 1'b0;
    send_img_a(32'h1111_0000);
    tests_run++;
    if (a_out_valid !== 1'b1 || a_frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL missing_last_restart: got valid=%b err=%b want 1/0", a_out_valid, a_frame_err);
    end
    for (int j = 1; j <= 4; j++) send_a(32'h2222_0000 | 32'(j), 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (a_out_valid !== 1'b0 || a_out_image !== 256'h0 || a_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset: got valid=%b ready=%b img=%h", a_out_valid, a_in_ready, a_out_image);
    end
    a_out_ready = 1'b1;
    send_img_a(32'h3333_0000);
    tests_run++;
    if (a_out_valid !== 1'b1 || a_frame_err !== 1'b0 ||
        a_out_image !== 256'h33330001_33330002_33330003_33330004_33330005_33330006_33330007_33330008) begin
      tests_failed++;
      $display("FAIL midreset_recover: got valid=%b err=%b img=%h", a_out_valid, a_frame_err, a_out_image);
    end
    tick();
  endtask

  task automatic test_small_geometry();
    logic [31:0] exp_img [5];
    logic [7:0]  words [4];
    int n_out = 0;
    exp_img[0] = 32'hAABBCCDD;
    exp_img[1] = 32'hAABBCCDD;
    exp_img[2] = 32'hAABBCCDD;
    exp_img[3] = 32'hAABBCCDD;
    exp_img[4] = 32'h01020304;
    b_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        words[0] = 8'hAA; words[1] = 8'hBB; words[2] = 8'hCC; words[3] = 8'hDD;
      end else begin
        words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03; words[3] = 8'h04;
      end
      for (int j = 0; j < 4; j++) begin
        send_b(words[j], j == 3);
        if (b_out_valid === 1'b1) begin
          tests_run++;
          if (n_out > 4 || b_out_image !== exp_img[n_out % 5]) begin
            tests_failed++;
            $display("FAIL small_image: output %0d got %h", n_out, b_out_image);
          end
          n_out++;
        end
      end
    end
    tests_run++;
    if (n_out != 5 || b_frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL small_count: got %0d outputs err=%b want 5/0", n_out, b_frame_err);
    end
    tick();
    tests_run++;
    if (b_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL small_drain: got %b want 0", b_out_valid);
    end
`ifdef ISD_IMG_COUNT_EN
    tests_run++;
    if (b_img_count !== 2'd1) begin
      tests_failed++;
      $display("FAIL small_img_count_wrap: got %0d want 1", b_img_count);
    end
`endif
  endtask

  initial begin
    reset       = 1'b1;
    a_in_data   = '0;
    a_in_valid  = 1'b0;
    a_in_last   = 1'b0;
    a_out_ready = 1'b0;
    b_in_data   = '0;
    b_in_valid  = 1'b0;
    b_in_last   = 1'b0;
    b_out_ready = 1'b0;
    #1;

    test_reset();
    test_single_image();
    test_back_to_back();
    test_hold();
    test_early_last();
    test_missing_last_and_reset();
    test_small_geometry();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_image_stream_deserializer
